// File: rtl/scalar_point_mul_ctrl.sv
// k*P sequencer: left-to-right double-and-add time-sharing one combinational PointAdder.
// Build option SCALARMUL_CONST_TIME_EN: ADD always follows DBL (dummy add on zero bits) for fixed latency.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module PointAdder #(
  parameter int W       = `DATAWIDTH,
  parameter int PRIME   = 251,
  parameter int CURVE_A = 2
) (
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  output logic [W-1:0] x3,
  output logic [W-1:0] y3
);
  localparam logic [W-1:0] PM    = W'(PRIME);
  localparam logic [W-1:0] EXP   = W'(PRIME - 2);
  localparam logic [W-1:0] CA    = W'(CURVE_A);
  localparam logic [W-1:0] THREE = W'(3);

  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PM}) s = s - {1'b0, PM};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
    return fadd(a, (b == '0) ? '0 : PM - b);
  endfunction

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(prod % {{W{1'b0}}, PM});
  endfunction

  // Fermat inverse a^(p-2), unrolled square-and-multiply
  function automatic logic [W-1:0] finv(input logic [W-1:0] a);
    logic [W-1:0] r;
    logic [W-1:0] b;
    r = W'(1);
    b = a;
    for (int i = 0; i < W; i++) begin
      if (EXP[i]) r = fmul(r, b);
      b = fmul(b, b);
    end
    return r;
  endfunction

  logic [W-1:0] num, den, lam;

  always_comb begin
    num = '0;
    den = '0;
    lam = '0;
    x3  = '0;
    y3  = '0;
    if (x1 == '0 && y1 == '0) begin
      x3 = x2;
      y3 = y2;
    end else if (x2 == '0 && y2 == '0) begin
      x3 = x1;
      y3 = y1;
    end else if (x1 == x2 && fadd(y1, y2) == '0) begin
      x3 = '0;  // P + (-P), including doubling a y=0 point
      y3 = '0;
    end else begin
      if (x1 == x2) begin
        num = fadd(fmul(THREE, fmul(x1, x1)), CA);
        den = fadd(y1, y1);
      end else begin
        num = fsub(y2, y1);
        den = fsub(x2, x1);
      end
      lam = fmul(num, finv(den));
      x3  = fsub(fsub(fmul(lam, lam), x1), x2);
      y3  = fsub(fmul(lam, fsub(x1, x3)), y1);
    end
  end
endmodule

module scalar_point_mul_ctrl #(
  parameter int KEYWIDTH = `DATAWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KEYWIDTH-1:0]   k,
  input  logic [`DATAWIDTH-1:0] Px,
  input  logic [`DATAWIDTH-1:0] Py,
  output logic                  busy,
  output logic                  done,
  output logic [`DATAWIDTH-1:0] Rx,
  output logic [`DATAWIDTH-1:0] Ry
);
  localparam int W  = `DATAWIDTH;
  localparam int CW = $clog2(KEYWIDTH + 1);

  typedef enum logic [1:0] {IDLE, DBL, ADD, FIN} state_t;

  state_t              state;
  logic [KEYWIDTH-1:0] kreg;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        preg_x, preg_y, racc_x, racc_y;
  logic [W-1:0]        opb_x, opb_y, sum_x, sum_y, acc_nx_x, acc_nx_y;
  logic                kbit;

  assign kbit  = kreg[KEYWIDTH-1];
  assign opb_x = (state == ADD) ? preg_x : racc_x;
  assign opb_y = (state == ADD) ? preg_y : racc_y;

  PointAdder #(.W(W)) u_adder (
    .x1(racc_x), .y1(racc_y), .x2(opb_x), .y2(opb_y), .x3(sum_x), .y3(sum_y)
  );

  always_comb begin
    acc_nx_x = sum_x;
    acc_nx_y = sum_y;
`ifdef SCALARMUL_CONST_TIME_EN
    if (state == ADD && !kbit) begin
      acc_nx_x = racc_x;
      acc_nx_y = racc_y;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Rx     <= '0;
      Ry     <= '0;
      racc_x <= '0;
      racc_y <= '0;
      kreg   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kreg   <= k;
            preg_x <= Px;
            preg_y <= Py;
            racc_x <= '0;
            racc_y <= '0;
            cnt    <= CW'(KEYWIDTH);
            busy   <= 1'b1;
            state  <= DBL;
          end
        end
        DBL: begin
          racc_x <= acc_nx_x;
          racc_y <= acc_nx_y;
`ifdef SCALARMUL_CONST_TIME_EN
          state <= ADD;
`else
          if (kbit) begin
            state <= ADD;
          end else begin
            kreg <= kreg << 1;
            cnt  <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              // result leaves on the same edge Racc takes its final value
              Rx    <= acc_nx_x;
              Ry    <= acc_nx_y;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end
          end
`endif
        end
        ADD: begin
          racc_x <= acc_nx_x;
          racc_y <= acc_nx_y;
          kreg   <= kreg << 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            Rx    <= acc_nx_x;
            Ry    <= acc_nx_y;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            state <= DBL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scalar_point_mul_ctrl.sv
// Directed bench for scalar_point_mul_ctrl on y^2 = x^3 + 2x + 4 over GF(251), G = (0,2).
module tb_scalar_point_mul_ctrl;
  localparam int PR = 251;
  localparam int CA = 2;

  typedef struct { int x; int y; } pt_t;
  typedef struct { int x; int y; int lat; } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, busy, done;
  logic [7:0] k, Px, Py, Rx, Ry;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  pt_t  g, g255, p7, inf_pt;

  always #5 clk = ~clk;

  scalar_point_mul_ctrl #(.KEYWIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .Px(Px), .Py(Py),
    .busy(busy), .done(done), .Rx(Rx), .Ry(Ry)
  );

  function automatic int md(input int v);
    return ((v % PR) + PR) % PR;
  endfunction

  function automatic int inv(input int a);
    for (int i = 1; i < PR; i++) if (md(a * i) == 1) return i;
    return 0;
  endfunction

  function automatic pt_t padd(input pt_t p, input pt_t q);
    pt_t r;
    int  lam;
    r.x = 0; r.y = 0;
    if (p.x == 0 && p.y == 0) return q;
    if (q.x == 0 && q.y == 0) return p;
    if (p.x == q.x && md(p.y + q.y) == 0) return r;
    if (p.x == q.x) lam = md(md(3 * p.x * p.x + CA) * inv(md(2 * p.y)));
    else            lam = md(md(q.y - p.y) * inv(md(q.x - p.x)));
    r.x = md(lam * lam - p.x - q.x);
    r.y = md(lam * (p.x - r.x) - p.y);
    return r;
  endfunction

  // repeated addition: deliberately not double-and-add
  function automatic pt_t smul(input int n, input pt_t p);
    pt_t r;
    r.x = 0; r.y = 0;
    for (int i = 0; i < n; i++) r = padd(r, p);
    return r;
  endfunction

  function automatic int exp_lat(input logic [7:0] kk);
`ifdef SCALARMUL_CONST_TIME_EN
    return 17 + 0 * $countones(kk);
`else
    return 9 + $countones(kk);
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [7:0] kk, input pt_t p, input pt_t r);
    exp_t e;
    @(posedge clk); #1;
    k = kk; Px = 8'(p.x); Py = 8'(p.y); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.x = r.x; e.y = r.y; e.lat = exp_lat(kk);
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int n0, input bit chk_busy);
    exp_t e;
    int   n;
    bit   seen, busy_ok;
    n = n0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 60) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (seen && busy !== 1'b0) busy_ok = 1'b0;
    e = sb.pop_front();
    check($sformatf("%s.done_cycle", tag), n, e.lat);
    if (chk_busy) check($sformatf("%s.busy", tag), int'(busy_ok), 1);
    check($sformatf("%s.Rx", tag), int'(Rx), e.x);
    check($sformatf("%s.Ry", tag), int'(Ry), e.y);
  endtask

  initial begin : main
    exp_t e;
    int   n, d1, d2;
    g.x = 0; g.y = 2;
    inf_pt.x = 0; inf_pt.y = 0;
    g255 = smul(255, g);
    p7   = smul(7, g);
    rst = 1'b1; start = 1'b0; k = '0; Px = '0; Py = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.Rx", int'(Rx), 0);
    check("reset.Ry", int'(Ry), 0);

    start_op(8'h00, g, inf_pt);              wait_done("k00", 0, 1);
    start_op(8'h01, g, g);                   wait_done("k01", 0, 1);
    start_op(8'h02, g, padd(g, g));          wait_done("k02", 0, 1);
    start_op(8'h03, g, padd(padd(g, g), g)); wait_done("k03", 0, 1);
    start_op(8'hFF, g, g255);                wait_done("kFF", 0, 1);
    start_op(8'h5A, p7, smul(90, p7));       wait_done("k5A_p7", 0, 1);

    // start pulsed mid-computation with a different scalar
    start_op(8'hFF, g, g255);
    repeat (3) @(negedge clk);
    k = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 4, 0);

    // reset sampled on edge 5 of a k=FF run
    start_op(8'hFF, g, g255);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check("abort.Rx", int'(Rx), 0);
    check("abort.Ry", int'(Ry), 0);
    rst = 1'b0;
    e = sb.pop_front();
    start_op(8'h01, g, g); wait_done("post_reset", 0, 1);

    // start held high across two operations
    @(posedge clk); #1;
    k = 8'h01; Px = 8'(g.x); Py = 8'(g.y); start = 1'b1;
    @(posedge clk); #1;
    k = 8'h02;
    e.x = g.x; e.y = g.y; e.lat = exp_lat(8'h01);
    sb.push_back(e);
    e = '{x: padd(g, g).x, y: padd(g, g).y, lat: 0};
    sb.push_back(e);
    n = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && n < 80) begin
      @(negedge clk); n++;
      if (done) begin
        e = sb.pop_front();
        if (d1 < 0) d1 = n; else d2 = n;
        check($sformatf("b2b%0d.Rx", (d2 < 0) ? 1 : 2), int'(Rx), e.x);
        check($sformatf("b2b%0d.Ry", (d2 < 0) ? 1 : 2), int'(Ry), e.y);
      end
    end
    start = 1'b0;
    check("b2b.first_done", d1, exp_lat(8'h01));
    check("b2b.gap", d2 - d1, exp_lat(8'h02) + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
